instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage for the single-cycle/pipelined RV32I core. Holds the fetch PC, issues word requests to instruction memory over a valid/ready request channel, buffers returned words in a 2-entry FIFO, and presents {pc, instr, op} to decode over a valid/ready handshake. Branch/jump resolution redirects it, which flushes buffered and in-flight fetches.

## Interface
- `XLEN`, 32: address/data width; only 32 is supported.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_rsp_valid`  in  1  response word valid. Responses are in order, one per accepted request, with latency ≥1 cycle.
- `imem_rsp_data`  in  32  instruction word.
- `redirect_valid`  in  1  PC redirect from branch/jump resolution.
- `redirect_pc`  in  32  new fetch address; bits [1:0] are ignored (treated as 00).
- `out_valid`  out  1  decode-side entry valid.
- `out_ready`  in  1  decode accepts the entry.
- `out_pc`  out  32  PC of the presented instruction.
- `out_instr`  out  32  instruction word.
- `out_op`  out  7  `out_instr[6:0]`; drives the decoder opcode input.

## Operation
- State:
  - `pc_q`: next fetch address.
  - `inflight` (0..2): accepted requests not yet answered.
  - `drop` (0..2): the subset of `inflight` to discard.
  - FIFO of {pc, instr}, 2 entries, with `count` (0..2).
  - An internal PC queue tracks the address of each in-flight request; each response is paired with its address.
- Issue:
  - `imem_req_valid = !rst && !redirect_valid && (inflight + count − deq) < 2`, where `deq = out_valid && out_ready`.
  - `imem_req_addr = pc_q`.
  - On accept (`imem_req_valid && imem_req_ready`): `pc_q += 4` (wraps 32'hFFFF_FFFC → 0), and `inflight += 1`.
  - `imem_req_valid` may drop without acceptance only in a redirect cycle.
- Response:
  - On `imem_rsp_valid`, `inflight −= 1`.
  - If `drop > 0`: `drop −= 1` and the word is discarded.
  - Otherwise {pc, data} is pushed into the FIFO.
  - `imem_rsp_valid` with `inflight == 0` is ignored.
- Dequeue: `out_valid = (count != 0) && !redirect_valid`. The head is popped on `out_valid && out_ready`. Push and pop may occur in the same cycle; `count` is unchanged in that case.
- Redirect (a cycle with `redirect_valid == 1`):
  - `pc_q <= {redirect_pc[31:2], 2'b00}`.
  - FIFO is flushed (`count <= 0`).
  - `drop <= inflight − (imem_rsp_valid ? 1 : 0)`; a response arriving in the redirect cycle is also discarded.
  - No request is issued and no pop occurs.
  - Back-to-back redirects: the last one wins; `drop` is recomputed each cycle.
- Overflow is impossible by the credit rule. The FIFO never exceeds 2 entries, and `inflight + count ≤ 2` at all times.

## Timing
- Reset values: `pc_q = RESET_PC`, `inflight = drop = count = 0`, `imem_req_valid = 0`, `out_valid = 0`. `out_pc`, `out_instr` and `out_op` read 0 while empty.
- Reset mid-operation clears all state in one cycle. The memory is reset by the same `rst`, so no stale responses follow.
- First request: the cycle after `rst` deasserts, with `imem_req_addr = RESET_PC`.
- Latency: a response in cycle t becomes `out_valid` in t+1. The FIFO is registered, with no rsp→out bypass.
- Throughput: 1 instruction/cycle with latency-1 memory and `out_ready` held high. This relies on the credit term counting the same-cycle pop.
- After a redirect in cycle t:
  - The first request to the new PC is in t+1.
  - With latency-1 memory, the first new instruction appears at `out_valid` in t+3.
- `imem_req_ready → imem_req_valid` has no combinational path. `out_ready → imem_req_valid` is a combinational path, by design.

## Test plan
- Reset, then a latency-1 memory returning `0x00000013 + addr`, `out_ready = 1` → requests at 0x0, 0x4, 0x8… on consecutive cycles. `out_valid` is first high 2 cycles after the first request with `out_pc = 0`, `out_op = 7'h13`, then one instruction per cycle.
- `out_ready = 0` for 10 cycles → `count` saturates at 2 and `imem_req_valid = 0`. On release, 0x0 and 0x4 drain in order with no loss or duplication.
- Redirect to 0x100 with 2 requests in flight (latency-3 memory) → the two pending responses are discarded, `drop` goes 2→0, and the next `out_pc` is 0x100.
- `redirect_pc = 0x203` → the fetch address is 0x200.
- Redirect in the same cycle as `imem_rsp_valid` and a pending `out_ready` → the response is discarded, no pop occurs, and `out_valid = 0` that cycle.
- `rst` asserted mid-stream with the FIFO full → next cycle all outputs are at reset values, and the first request after release is to `RESET_PC`.
- `pc_q = 0xFFFFFFFC` → the next request wraps to 0x0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// RV32I instruction fetch stage: credit-limited word requests, in-order response pairing,
// and a 2-entry {pc, instr} buffer feeding decode. A redirect flushes buffered and in-flight words.
module instr_fetch_unit #(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic [6:0]      out_op
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [1:0]      inflight_q, inflight_d;
    logic [1:0]      drop_q, drop_d;
    logic [1:0]      count_q, count_d;

    logic [XLEN-1:0] fifo_pc_q [2];
    logic [XLEN-1:0] fifo_pc_d [2];
    logic [XLEN-1:0] fifo_instr_q [2];
    logic [XLEN-1:0] fifo_instr_d [2];
    logic            fifo_rd_q, fifo_rd_d;
    logic            fifo_wr_q, fifo_wr_d;

    logic [XLEN-1:0] pcq_q [2];
    logic [XLEN-1:0] pcq_d [2];
    logic            pcq_rd_q, pcq_rd_d;
    logic            pcq_wr_q, pcq_wr_d;

    logic            deq;
    logic            req_fire;
    logic            rsp_fire;
    logic            push;
    logic [2:0]      credit;
    logic [XLEN-1:0] redirect_target;

    assign redirect_target = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};

    assign out_valid = (count_q != 2'd0) && !redirect_valid;
    assign deq       = out_valid && out_ready;

    // The same-cycle pop frees a slot, which is what sustains one fetch per cycle.
    assign credit         = {1'b0, inflight_q} + {1'b0, count_q} - {2'b00, deq};
    assign imem_req_valid = !rst && !redirect_valid && (credit < 3'd2);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_fire = imem_rsp_valid && (inflight_q != 2'd0);
    assign push     = rsp_fire && (drop_q == 2'd0) && !redirect_valid;

    assign out_pc    = (count_q != 2'd0) ? fifo_pc_q[fifo_rd_q]    : '0;
    assign out_instr = (count_q != 2'd0) ? fifo_instr_q[fifo_rd_q] : '0;
    assign out_op    = out_instr[6:0];

    always_comb begin
        pc_d         = pc_q;
        drop_d       = drop_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;
        fifo_rd_d    = fifo_rd_q;
        fifo_wr_d    = fifo_wr_q;
        pcq_d        = pcq_q;
        pcq_rd_d     = pcq_rd_q;
        pcq_wr_d     = pcq_wr_q;

        inflight_d = inflight_q + {1'b0, req_fire} - {1'b0, rsp_fire};
        count_d    = count_q + {1'b0, push} - {1'b0, deq};

        if (req_fire) begin
            pcq_d[pcq_wr_q] = pc_q;
            pcq_wr_d        = ~pcq_wr_q;
            pc_d            = pc_q + XLEN'(4);
        end

        // Every response consumes its address slot, including the ones being discarded.
        if (rsp_fire) begin
            pcq_rd_d = ~pcq_rd_q;
        end

        if (push) begin
            fifo_pc_d[fifo_wr_q]    = pcq_q[pcq_rd_q];
            fifo_instr_d[fifo_wr_q] = imem_rsp_data;
            fifo_wr_d               = ~fifo_wr_q;
        end

        if (deq) begin
            fifo_rd_d = ~fifo_rd_q;
        end

        if (redirect_valid) begin
            pc_d      = redirect_target;
            count_d   = 2'd0;
            fifo_rd_d = 1'b0;
            fifo_wr_d = 1'b0;
            drop_d    = inflight_q - {1'b0, rsp_fire};
        end else if (rsp_fire && (drop_q != 2'd0)) begin
            drop_d = drop_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= 2'd0;
            drop_q     <= 2'd0;
            count_q    <= 2'd0;
            fifo_rd_q  <= 1'b0;
            fifo_wr_q  <= 1'b0;
            pcq_rd_q   <= 1'b0;
            pcq_wr_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_pc_q[i]    <= '0;
                fifo_instr_q[i] <= '0;
                pcq_q[i]        <= '0;
            end
        end else begin
            pc_q         <= pc_d;
            inflight_q   <= inflight_d;
            drop_q       <= drop_d;
            count_q      <= count_d;
            fifo_rd_q    <= fifo_rd_d;
            fifo_wr_q    <= fifo_wr_d;
            pcq_rd_q     <= pcq_rd_d;
            pcq_wr_q     <= pcq_wr_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_instr_q <= fifo_instr_d;
            pcq_q        <= pcq_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a fixed-latency in-order memory model
// answering each accepted address A with the word 0x13 + A.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [6:0]  out_op;

    int errorCount = 0;
    int checkCount = 0;
    int cycleNum   = 0;
    int memLat     = 1;

    logic [31:0] memAddrQ [$];
    int          memDueQ  [$];
    logic        rspNow;

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_op         (out_op)
    );

    // Free-running clock; rising edge at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges the main sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected sequence end");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count one comparison and report it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, including the memory response.
    task automatic applyStimulus(input logic rstIn, input logic readyIn, input logic redirIn,
                                 input logic [31:0] redirPcIn);
        rst            = rstIn;
        out_ready      = readyIn;
        redirect_valid = redirIn;
        redirect_pc    = redirPcIn;
        rspNow         = !rstIn && (memDueQ.size() > 0) && (memDueQ[0] <= cycleNum);
        imem_rsp_valid = rspNow;
        imem_rsp_data  = rspNow ? (memAddrQ[0] + 32'h13) : 32'h0;
        #1;
    endtask

    // Record what the DUT handed the memory this cycle, cross the rising edge, update the model.
    task automatic advance();
        logic        accepted;
        logic [31:0] addr;
        accepted = imem_req_valid && imem_req_ready;
        addr     = imem_req_addr;
        @(posedge clk);
        if (rst) begin
            memAddrQ.delete();
            memDueQ.delete();
        end else begin
            if (rspNow) begin
                void'(memAddrQ.pop_front());
                void'(memDueQ.pop_front());
            end
            if (accepted) begin
                memAddrQ.push_back(addr);
                memDueQ.push_back(cycleNum + memLat);
            end
        end
        cycleNum++;
        @(negedge clk);
    endtask

    task automatic resetDut(input int lat);
        memLat = lat;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        advance();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        advance();
    endtask

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        rspNow         = 1'b0;
        @(negedge clk);

        // Reset state
        resetDut(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_pc", out_pc, 32'h0);
        checkOutput("rst_out_instr", out_instr, 32'h0);
        checkOutput("rst_out_op", 32'(out_op), 32'h0);
        advance();

        // Streaming with latency-1 memory and decode always ready
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t1_first_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("t1_first_req_addr", imem_req_addr, 32'h0);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t1_no_bypass", 32'(out_valid), 32'd0);
        checkOutput("t1_second_req_addr", imem_req_addr, 32'h4);
        advance();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            checkOutput("t1_stream_valid", 32'(out_valid), 32'd1);
            checkOutput("t1_stream_pc", out_pc, 32'(4 * k));
            checkOutput("t1_stream_op", 32'(out_op), (32'h13 + 32'(4 * k)) & 32'h7F);
            checkOutput("t1_stream_req", imem_req_addr, 32'(4 * k + 8));
            advance();
        end

        // Backpressure: decode stalls for 10 cycles, then drains
        resetDut(1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            if (i == 0) checkOutput("t2_first_req_addr", imem_req_addr, 32'h0);
            if (i == 9) begin
                checkOutput("t2_full_req_valid", 32'(imem_req_valid), 32'd0);
                checkOutput("t2_full_out_valid", 32'(out_valid), 32'd1);
                checkOutput("t2_full_head_pc", out_pc, 32'h0);
            end
            advance();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t2_drain0_pc", out_pc, 32'h0);
        checkOutput("t2_release_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("t2_release_req_addr", imem_req_addr, 32'h8);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t2_drain1_pc", out_pc, 32'h4);
        checkOutput("t2_drain1_instr", out_instr, 32'h17);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t2_drain2_pc", out_pc, 32'h8);
        checkOutput("t2_drain2_instr", out_instr, 32'h1B);
        advance();

        // Redirect with two requests in flight on a latency-3 memory
        resetDut(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t3_req0_addr", imem_req_addr, 32'h0);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t3_req1_addr", imem_req_addr, 32'h4);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
        checkOutput("t3_redirect_req_valid", 32'(imem_req_valid), 32'd0);
        advance();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            checkOutput("t3_discard_out_valid", 32'(out_valid), 32'd0);
            if (i == 1) checkOutput("t3_new_req_addr", imem_req_addr, 32'h100);
            advance();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t3_new_out_valid", 32'(out_valid), 32'd1);
        checkOutput("t3_new_out_pc", out_pc, 32'h100);
        checkOutput("t3_new_out_instr", out_instr, 32'h113);
        advance();

        // Unaligned redirect target, latency-1 memory, idle pipeline
        resetDut(1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h203);
        checkOutput("t4_redirect_req_valid", 32'(imem_req_valid), 32'd0);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t4_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("t4_req_addr", imem_req_addr, 32'h200);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t4_t2_out_valid", 32'(out_valid), 32'd0);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t4_t3_out_valid", 32'(out_valid), 32'd1);
        checkOutput("t4_t3_out_pc", out_pc, 32'h200);
        checkOutput("t4_t3_out_instr", out_instr, 32'h213);
        advance();

        // Redirect coinciding with a response and a ready decode stage
        resetDut(1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            advance();
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h40);
        checkOutput("t5_rsp_present", 32'(imem_rsp_valid), 32'd1);
        checkOutput("t5_redirect_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_redirect_req_valid", 32'(imem_req_valid), 32'd0);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t5_after_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_after_req_addr", imem_req_addr, 32'h40);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t5_gap_out_valid", 32'(out_valid), 32'd0);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t5_new_out_valid", 32'(out_valid), 32'd1);
        checkOutput("t5_new_out_pc", out_pc, 32'h40);
        advance();

        // Reset asserted while the buffer is full
        resetDut(1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            advance();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t6_full_before_rst", 32'(out_valid), 32'd1);
        advance();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        advance();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t6_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_out_pc", out_pc, 32'h0);
        checkOutput("t6_out_instr", out_instr, 32'h0);
        checkOutput("t6_out_op", 32'(out_op), 32'h0);
        checkOutput("t6_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("t6_req_addr", imem_req_addr, 32'h0);
        advance();

        // Fetch address wraps past the top of the address space
        resetDut(1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t7_top_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t7_wrap_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("t7_wrap_req_addr", imem_req_addr, 32'h0);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t7_top_out_pc", out_pc, 32'hFFFF_FFFC);
        checkOutput("t7_top_out_instr", out_instr, 32'h0000_000F);
        checkOutput("t7_top_out_op", 32'(out_op), 32'h0F);
        advance();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t7_wrap_out_pc", out_pc, 32'h0);
        checkOutput("t7_wrap_out_instr", out_instr, 32'h13);
        advance();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
